// File: rtl/decoder_2to4_timed.sv
// Registered 2-to-4 decoder for the receive end of the 2-bit line code.
// Each accepted code drives one one-hot line for HOLD_CYCLES, followed by a GAP_CYCLES idle gap.
module decoder_2to4_timed #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in_valid,
  input  logic y0,
  input  logic y1,
  output logic in_ready,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic busy,
  output logic done,
  output logic abort
);

  typedef enum logic [1:0] {StIdle, StActive, StGap} state_e;

  localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GapLoad  = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
  localparam bit         NoGap    = (GAP_CYCLES == 0);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] code_q, code_d;
  logic [3:0] d_q, d_d;
  logic       done_q, done_d;
  logic       abort_q, abort_d;
  logic       accept;

  // Gated by rst so the sender never sees ready while the block is held in reset.
  assign in_ready = en & ~rst & (state_q == StIdle);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    done_d  = 1'b0;
    abort_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          code_d  = {y1, y0};
          cnt_d   = HoldLoad;
          state_d = StActive;
        end
      end
      StActive: begin
        // A falling enable wins over a hold that completes on the same edge.
        if (!en || cnt_q == 8'd0) begin
          abort_d = ~en;
          done_d  = en;
          cnt_d   = GapLoad;
          state_d = NoGap ? StIdle : StGap;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StGap: begin
        if (cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    d_d = 4'b0000;
    if (state_d == StActive) begin
      unique case (code_d)
        2'b00:   d_d = 4'b0001;
        2'b01:   d_d = 4'b0010;
        2'b10:   d_d = 4'b0100;
        2'b11:   d_d = 4'b1000;
        default: d_d = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      code_q  <= 2'b00;
      d_q     <= 4'b0000;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      d_q     <= d_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign abort = abort_q;
  assign d0    = d_q[0];
  assign d1    = d_q[1];
  assign d2    = d_q[2];
  assign d3    = d_q[3];

endmodule

// File: tb/tb_decoder_2to4_timed.sv
// Directed bench: three decoder instances cover HOLD/GAP = 4/1, 1/0 and 2/3.
module tb_decoder_2to4_timed;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic y0, y1;
  logic a_rst, a_en, a_valid, a_in_ready, a_busy, a_done, a_abort;
  logic b_rst, b_en, b_valid, b_in_ready, b_busy, b_done, b_abort;
  logic c_rst, c_en, c_valid, c_in_ready, c_busy, c_done, c_abort;
  logic [3:0] a_d, b_d, c_d;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  decoder_2to4_timed #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .in_valid(a_valid), .y0(y0), .y1(y1),
    .in_ready(a_in_ready), .d0(a_d[0]), .d1(a_d[1]), .d2(a_d[2]), .d3(a_d[3]),
    .busy(a_busy), .done(a_done), .abort(a_abort)
  );

  decoder_2to4_timed #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .in_valid(b_valid), .y0(y0), .y1(y1),
    .in_ready(b_in_ready), .d0(b_d[0]), .d1(b_d[1]), .d2(b_d[2]), .d3(b_d[3]),
    .busy(b_busy), .done(b_done), .abort(b_abort)
  );

  decoder_2to4_timed #(.HOLD_CYCLES(2), .GAP_CYCLES(3)) u_c (
    .clk(clk), .rst(c_rst), .en(c_en), .in_valid(c_valid), .y0(y0), .y1(y1),
    .in_ready(c_in_ready), .d0(c_d[0]), .d1(c_d[1]), .d2(c_d[2]), .d3(c_d[3]),
    .busy(c_busy), .done(c_done), .abort(c_abort)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_d;
    {y1, y0} = 2'b00;
    a_rst = 1'b1; a_en = 1'b1; a_valid = 1'b0;
    b_rst = 1'b1; b_en = 1'b1; b_valid = 1'b0;
    c_rst = 1'b1; c_en = 1'b1; c_valid = 1'b0;
    #1;
    step();
    step();
    check("rst_ready_a", a_in_ready, 1'b0);
    check("rst_busy_a", a_busy, 1'b0);
    check("rst_d_a", a_d, 4'b0000);
    check("rst_done_a", a_done, 1'b0);
    check("rst_abort_a", a_abort, 1'b0);
    check("rst_ready_c", c_in_ready, 1'b0);
    #3;
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    step();
    check("post_rst_ready_a", a_in_ready, 1'b1);
    check("post_rst_ready_b", b_in_ready, 1'b1);

    // Sweep all four codes back-to-back; scramble y during ACTIVE.
    a_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      {y1, y0} = c[1:0];
      exp_d = 4'b0001 << c;
      step();
      for (int k = 0; k < 4; k++) begin
        check("sweep_d", a_d, exp_d);
        check("sweep_busy", a_busy, 1'b1);
        check("sweep_ready", a_in_ready, 1'b0);
        check("sweep_done_early", a_done, 1'b0);
        {y1, y0} = 2'($urandom_range(0, 3));
        step();
      end
      check("sweep_d_end", a_d, 4'b0000);
      check("sweep_done", a_done, 1'b1);
      check("sweep_gap_busy", a_busy, 1'b1);
      check("sweep_gap_ready", a_in_ready, 1'b0);
      if (a_done) done_cnt++;
      step();
      check("sweep_idle_ready", a_in_ready, 1'b1);
      check("sweep_idle_busy", a_busy, 1'b0);
      check("sweep_idle_done", a_done, 1'b0);
      check("sweep_idle_d", a_d, 4'b0000);
    end
    check("sweep_done_count", 4'(done_cnt), 4'd4);

    // en low in IDLE with a pending code: no accept, code kept by sender.
    a_en = 1'b0;
    {y1, y0} = 2'b10;
    for (int k = 0; k < 3; k++) begin
      step();
      check("en_low_ready", a_in_ready, 1'b0);
      check("en_low_d", a_d, 4'b0000);
      check("en_low_busy", a_busy, 1'b0);
    end
    a_en = 1'b1;
    #1;
    check("en_high_ready", a_in_ready, 1'b1);

    // Abort after two active cycles.
    step();
    check("abort_d_1", a_d, 4'b0100);
    a_valid = 1'b0;
    step();
    check("abort_d_2", a_d, 4'b0100);
    a_en = 1'b0;
    step();
    check("abort_pulse", a_abort, 1'b1);
    check("abort_d_low", a_d, 4'b0000);
    check("abort_no_done", a_done, 1'b0);
    check("abort_gap_busy", a_busy, 1'b1);
    step();
    check("abort_pulse_end", a_abort, 1'b0);
    check("abort_busy_clear", a_busy, 1'b0);
    check("abort_no_done_2", a_done, 1'b0);
    check("abort_ready_en_low", a_in_ready, 1'b0);
    a_en = 1'b1;

    // Asynchronous reset mid-ACTIVE.
    a_valid = 1'b1;
    {y1, y0} = 2'b01;
    step();
    check("pre_rst_d", a_d, 4'b0010);
    a_valid = 1'b0;
    #2;
    a_rst = 1'b1;
    #1;
    check("async_rst_d", a_d, 4'b0000);
    check("async_rst_busy", a_busy, 1'b0);
    check("async_rst_ready", a_in_ready, 1'b0);
    a_rst = 1'b0;
    step();
    check("after_rst_ready", a_in_ready, 1'b1);
    check("after_rst_d", a_d, 4'b0000);

    // Zero gap: HOLD=1, GAP=0, code 11 twice.
    b_valid = 1'b1;
    {y1, y0} = 2'b11;
    step();
    check("zg_d3_1", b_d, 4'b1000);
    check("zg_ready_0", b_in_ready, 1'b0);
    check("zg_busy_1", b_busy, 1'b1);
    step();
    check("zg_d_low", b_d, 4'b0000);
    check("zg_done_1", b_done, 1'b1);
    check("zg_ready_1", b_in_ready, 1'b1);
    check("zg_busy_0", b_busy, 1'b0);
    step();
    check("zg_d3_2", b_d, 4'b1000);
    check("zg_done_0", b_done, 1'b0);
    b_valid = 1'b0;
    step();
    check("zg_done_2", b_done, 1'b1);
    check("zg_ready_2", b_in_ready, 1'b1);

    // Reset during GAP: HOLD=2, GAP=3.
    c_valid = 1'b1;
    {y1, y0} = 2'b00;
    step();
    check("rg_d0_1", c_d, 4'b0001);
    step();
    check("rg_d0_2", c_d, 4'b0001);
    c_valid = 1'b0;
    step();
    check("rg_done", c_done, 1'b1);
    check("rg_gap_busy", c_busy, 1'b1);
    step();
    check("rg_gap_busy_2", c_busy, 1'b1);
    #2;
    c_rst = 1'b1;
    #1;
    check("rg_rst_busy", c_busy, 1'b0);
    check("rg_rst_ready", c_in_ready, 1'b0);
    step();
    check("rg_rst_busy_edge", c_busy, 1'b0);
    check("rg_rst_ready_edge", c_in_ready, 1'b0);
    #3;
    c_rst = 1'b0;
    c_valid = 1'b1;
    {y1, y0} = 2'b11;
    step();
    check("rg_first_d3_1", c_d, 4'b1000);
    check("rg_first_busy", c_busy, 1'b1);
    c_valid = 1'b0;
    step();
    check("rg_first_d3_2", c_d, 4'b1000);
    step();
    check("rg_first_done", c_done, 1'b1);
    check("rg_first_d_low", c_d, 4'b0000);
    step();
    step();
    check("rg_gap_ready_low", c_in_ready, 1'b0);
    step();
    check("rg_gap_ready_high", c_in_ready, 1'b1);
    check("rg_gap_busy_low", c_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_2to4_timed.md
# decoder_2to4_timed

Registered 2-to-4 decoder forming the receive end of the 2-bit line code produced by the team's 4-to-2 encoder. The code is `{y1,y0}`, with `y0 = d1|d3` and `y1 = d2|d3`. The block accepts one code per valid/ready handshake. It drives the matching one-hot output line `d0..d3` for a programmable number of cycles, then enforces a programmable idle gap before accepting the next code. It sits between the encoder-side link and downstream logic that needs a clean, time-bounded one-hot strobe.

## Interface
- `HOLD_CYCLES`, 4, cycles the one-hot output stays asserted per accepted code; legal range 1..255.
- `GAP_CYCLES`, 1, idle cycles after hold before `in_ready` returns high; legal range 0..255.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  block enable; when low, no code is accepted.
- `in_valid`  input  1  code on `y1,y0` is valid.
- `y0`  input  1  code bit 0 (LSB).
- `y1`  input  1  code bit 1 (MSB).
- `in_ready`  output  1  block can accept a code this cycle.
- `d0`, `d1`, `d2`, `d3`  output  1 each  one-hot decoded lines.
- `busy`  output  1  high in ACTIVE or GAP.
- `done`  output  1  one-cycle pulse when a hold period completes normally.
- `abort`  output  1  one-cycle pulse when a hold is cut short by `en` falling.

## Operation
- **Decode map:** `{y1,y0}` 00→`d0`, 01→`d1`, 10→`d2`, 11→`d3`. Exactly one `d` is high in ACTIVE. All `d` are low in IDLE and GAP.
- **Accept:** a code is accepted on a rising edge where `in_valid & in_ready`. `in_ready = en & (state==IDLE)`. `in_ready` is registered state decoded with `en`; it does not depend on `in_valid`.
- **State machine:** 8-bit down-counter `cnt`, 2-bit latched code `code_q`.
  - IDLE, on accept: latch `code_q`, set `cnt = HOLD_CYCLES-1`, go to ACTIVE.
  - ACTIVE, `en` low: go to GAP with `cnt = GAP_CYCLES-1`, or to IDLE if `GAP_CYCLES==0`. Pulse `abort`. Drop outputs. This case has priority over `cnt==0`.
  - ACTIVE, `en` high and `cnt==0`: pulse `done`. Go to GAP with `cnt = GAP_CYCLES-1`, or to IDLE if `GAP_CYCLES==0`.
  - ACTIVE, otherwise: decrement `cnt`.
  - GAP: at `cnt==0` go to IDLE, else decrement. `en` is ignored in GAP.
- **Registered outputs:** `d0..d3` are registered and decoded from `code_q` when the next state is ACTIVE. `done` and `abort` are registered pulses.
- **Input sampling:** `y0`/`y1` are sampled only on accept. Changes at any other time are ignored.
- **`en` in IDLE:** `en` low in IDLE holds IDLE and keeps `in_ready` low. Codes presented while `en` is low are not accepted and not lost; the sender keeps `in_valid` asserted.
- **Reset:** asynchronous assert forces IDLE, `cnt=0`, `code_q=00`, and all outputs low (`in_ready` low while `rst` high). It takes effect immediately, including mid-ACTIVE or mid-GAP. On the first edge after deassert the block is in IDLE; `in_ready` follows `en`.

## Timing
- Accept at edge N → selected `d` high from after edge N through edge N+HOLD_CYCLES, which is exactly HOLD_CYCLES cycles.
- `done` is high for the one cycle after edge N+HOLD_CYCLES, coincident with the first GAP cycle (or the IDLE cycle if `GAP_CYCLES==0`).
- `in_ready` is high again after edge N+HOLD_CYCLES+GAP_CYCLES, so the minimum accept-to-accept spacing is HOLD_CYCLES+GAP_CYCLES+1 edges.
- `busy` is high from after edge N until `in_ready` returns.
- If `en` falls so that it is sampled low at edge M inside ACTIVE, then after edge M: `d` low and `abort` high for 1 cycle. The gap then proceeds as normal.
- No combinational path from `in_valid`, `y0` or `y1` to any output.

## Test plan
- **Reset values:** assert `rst` mid-cycle with the default parameters → all outputs 0 immediately. Deassert with `en=1` → `in_ready=1` on the following cycle.
- **Full decode sweep:** HOLD=4, GAP=1. Send codes 00, 01, 10, 11 back-to-back with `in_valid` held high.
  - Each of `d0`, `d1`, `d2`, `d3` in turn is high for exactly 4 cycles, with all other `d` lines low.
  - Accept spacing is 6 edges.
  - `done` pulses 4 times.
- **Zero gap:** HOLD=1, GAP=0. Send code 11 twice → `d3` high for 1 cycle, `in_ready` high the next cycle, then `d3` high again. Accept spacing is 2 edges.
- **Abort:** HOLD=4. Accept code 10, then drop `en` after 2 active cycles → `d2` high 2 cycles, `abort`=1 for one cycle, `done` never asserts, `busy` clears after the gap.
- **Input stability:** change `y0`/`y1` every cycle during ACTIVE → the asserted `d` line does not change. With `en=0` and `in_valid=1` in IDLE, there is no accept and all `d` stay 0.
- **Reset mid-GAP:** HOLD=2, GAP=3. Pulse `rst` during the GAP cycles → `busy` and `in_ready` are 0 while `rst` is high. The next accept after release behaves like a first accept.
